// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared ctrl encodings, FSM states and tick divider for timer_ctrl
package timer_pkg;

  localparam int TICK_DIV = 12;
  localparam int CNT_W    = 5;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_CLR  = 2'b01;
  localparam logic [1:0] CTRL_RUN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  // Timer command issued while the controller sits in a given state.
  function automatic logic [1:0] ctrl_of(input state_t s);
    case (s)
      ST_RUN:    ctrl_of = CTRL_RUN;
      ST_PAUSED: ctrl_of = CTRL_HOLD;
      ST_DONE:   ctrl_of = CTRL_HOLD;
      default:   ctrl_of = CTRL_CLR;
    endcase
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// rtl/btn_pulse.sv - rising-edge detector for a button level input
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic armed;

  // armed stays low for the first cycle after reset so a button already
  // held through reset is absorbed into in_q instead of producing an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q  <= in;
      armed <= 1'b1;
    end
  end

  assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - interval controller driving an external tick timer (warn logic under TIMER_CTRL_WARN_EN)
module timer_ctrl
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [CNT_W-1:0] limit,
  input  logic [CNT_W-1:0] tmout,
  output logic [1:0]       ctrl,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             warn
);

  logic start_p, pause_p, abort_p;

  btn_pulse u_start (.clk(clk), .rst(rst), .in(start), .pulse(start_p));
  btn_pulse u_pause (.clk(clk), .rst(rst), .in(pause), .pulse(pause_p));
  btn_pulse u_abort (.clk(clk), .rst(rst), .in(abort), .pulse(abort_p));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             done_d;

  // Priority within each state: abort, then expiry, then start, then pause.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort_p) begin
          state_d = ST_IDLE;
        end else if (start_p) begin
          lim_d = limit;
          if (limit == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        state_d = abort_p ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (abort_p) begin
          state_d = ST_IDLE;
        end else if (tmout >= lim_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (pause_p) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (abort_p) begin
          state_d = ST_IDLE;
        end else if (start_p || pause_p) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl      <= CTRL_CLR;
      done      <= 1'b0;
      lim_q     <= '0;
      remaining <= '0;
    end else begin
      state_q <= state_d;
      ctrl    <= ctrl_of(state_d);
      done    <= done_d;
      lim_q   <= lim_d;
      if (state_q == ST_IDLE)
        remaining <= '0;
      else if (lim_q > tmout)
        remaining <= lim_q - tmout;
      else
        remaining <= '0;
    end
  end

  assign busy = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_PAUSED);

`ifdef TIMER_CTRL_WARN_EN
  assign warn = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) &&
                (remaining != '0) && (remaining <= CNT_W'(2));
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed self-checking bench for timer_ctrl with a tick timer model
module tb_timer_ctrl;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort;
  logic [4:0] limit, tmout;
  logic [1:0] ctrl;
  logic       busy, done, warn;
  logic [4:0] remaining;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int pre = 0;
  int t0, dc, bc, wcnt, wfirst, wlast;

  timer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .limit(limit), .tmout(tmout), .ctrl(ctrl), .busy(busy), .done(done),
    .remaining(remaining), .warn(warn)
  );

  always #5 clk = ~clk;

  // Timer model: clear on 01, advance one tick every TICK_DIV run cycles, hold on 00.
  always @(posedge clk) begin
    if (rst) begin
      pre   <= 0;
      tmout <= '0;
    end else if (ctrl == CTRL_CLR) begin
      pre   <= 0;
      tmout <= '0;
    end else if (ctrl == CTRL_RUN) begin
      if (pre == TICK_DIV - 1) begin
        pre   <= 0;
        tmout <= tmout + 5'd1;
      end else begin
        pre <= pre + 1;
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; limit = 5'd0;
    step(3);
    check("rst_ctrl", ctrl, 2'b01);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_remaining", remaining, 5'd0);
    check("rst_warn", warn, 1'b0);
    rst = 1'b0;
    step(2);

    // limit=3 plain run; limit changed mid-interval must be ignored
    limit = 5'd3; start = 1'b1;
    step(1);
    check("a_ctrl_e0", ctrl, 2'b01);
    check("a_busy_e0", busy, 1'b1);
    start = 1'b0;
    step(1);
    check("a_ctrl_e1", ctrl, 2'b10);
    limit = 5'd20;
    step(35);
    check("a_tmout_e36", tmout, 5'd2);
    step(1);
    check("a_tmout_e37", tmout, 5'd3);
    check("a_done_e37", done, 1'b0);
    check("a_remaining_e37", remaining, 5'd1);
    step(1);
    check("a_done_e38", done, 1'b1);
    check("a_ctrl_e38", ctrl, 2'b00);
    check("a_busy_e38", busy, 1'b0);
    step(1);
    check("a_done_e39", done, 1'b0);
    check("a_ctrl_e39", ctrl, 2'b00);

    // limit=5 with a 50-cycle pause at tmout=2
    limit = 5'd5; start = 1'b1;
    step(1);
    t0 = cyc;
    start = 1'b0;
    for (int i = 0; i < 100 && tmout != 5'd2; i++) step(1);
    check("b_reach_2", tmout, 5'd2);
    pause = 1'b1;
    step(1);
    check("b_ctrl_paused", ctrl, 2'b00);
    check("b_busy_paused", busy, 1'b1);
    pause = 1'b0;
    step(25);
    check("b_tmout_hold", tmout, 5'd2);
    step(24);
    pause = 1'b1;
    step(1);
    check("b_ctrl_resume", ctrl, 2'b10);
    pause = 1'b0;
    for (int i = 0; i < 200 && !done; i++) step(1);
    check("b_done_seen", done, 1'b1);
    check("b_done_cycle", cyc - t0, 112);

    // limit=4 abort at tmout=1
    limit = 5'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 100 && tmout != 5'd1; i++) step(1);
    check("c_reach_1", tmout, 5'd1);
    abort = 1'b1;
    dc = done_cnt;
    step(1);
    check("c_ctrl_abort", ctrl, 2'b01);
    check("c_busy_abort", busy, 1'b0);
    check("c_tmout_abort", tmout, 5'd1);
    abort = 1'b0;
    step(1);
    check("c_tmout_cleared", tmout, 5'd0);
    step(3);
    check("c_no_done", done_cnt, dc);

    // limit=0 goes straight to DONE
    limit = 5'd0;
    bc = busy_cnt; dc = done_cnt;
    start = 1'b1;
    step(1);
    check("d_done", done, 1'b1);
    check("d_ctrl", ctrl, 2'b00);
    check("d_busy", busy, 1'b0);
    start = 1'b0;
    step(1);
    check("d_done_once", done, 1'b0);
    step(2);
    check("d_busy_never", busy_cnt, bc);
    check("d_done_count", done_cnt, dc + 1);

    // abort coincident with expiry
    limit = 5'd1; start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 100 && tmout != 5'd1; i++) step(1);
    check("e_reach_1", tmout, 5'd1);
    abort = 1'b1;
    dc = done_cnt;
    step(1);
    check("e_ctrl_idle", ctrl, 2'b01);
    check("e_busy_idle", busy, 1'b0);
    check("e_done_low", done, 1'b0);
    abort = 1'b0;
    step(2);
    check("e_no_done", done_cnt, dc);

    // start and pause together from IDLE
    start = 1'b1; pause = 1'b1;
    step(1);
    check("e_sp_clear_ctrl", ctrl, 2'b01);
    check("e_sp_clear_busy", busy, 1'b1);
    start = 1'b0; pause = 1'b0;
    step(1);
    check("e_sp_run", ctrl, 2'b10);
    step(3);
    check("e_sp_still_run", ctrl, 2'b10);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(1);

    // warn window for limit=4
    limit = 5'd4; start = 1'b1;
    step(1);
    start = 1'b0;
    wcnt = 0; wfirst = -1; wlast = -1;
    for (int k = 1; k <= 55; k++) begin
      step(1);
      if (k == 25) check("f_remaining_e25", remaining, 5'd3);
      if (k == 26) check("f_remaining_e26", remaining, 5'd2);
      if (k == 38) check("f_remaining_e38", remaining, 5'd1);
      if (k == 50) check("f_done_e50", done, 1'b1);
      if (warn) begin
        wcnt++;
        if (wfirst < 0) wfirst = k;
        wlast = k;
      end
    end
`ifdef TIMER_CTRL_WARN_EN
    check("f_warn_first", wfirst, 26);
    check("f_warn_last", wlast, 49);
    check("f_warn_count", wcnt, 24);
`else
    check("f_warn_count", wcnt, 0);
`endif

    // reset in the middle of an interval
    limit = 5'd6; start = 1'b1;
    step(1);
    start = 1'b0;
    step(20);
    dc = done_cnt;
    rst = 1'b1;
    step(1);
    check("g_ctrl_rst", ctrl, 2'b01);
    check("g_busy_rst", busy, 1'b0);
    check("g_remaining_rst", remaining, 5'd0);
    rst = 1'b0;
    step(100);
    check("g_no_done", done_cnt, dc);
    check("g_idle", busy, 1'b0);

    // button held through reset release must not start
    start = 1'b1; rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    check("h_busy_held", busy, 1'b0);
    check("h_ctrl_held", ctrl, 2'b01);
    start = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
